// File: rtl/decimal_entry_encoder_if.sv
// Key inputs and entry/result outputs of the decimal entry encoder.
// master drives the keys, slave is the encoder.
interface decimal_entry_encoder_if;
    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned CURSOR_W   = 3;
    localparam int unsigned VALUE_W    = 41;

    logic                                key_next_n;
    logic                                key_inc_n;
    logic                                key_commit_n;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  digits_bcd;
    logic [CURSOR_W-1:0]                 cursor;
    logic [VALUE_W-1:0]                  value_out;
    logic                                value_valid;
    logic                                busy;

    modport master (
        output key_next_n, key_inc_n, key_commit_n,
        input  digits_bcd, cursor, value_out, value_valid, busy
    );

    modport slave (
        input  key_next_n, key_inc_n, key_commit_n,
        output digits_bcd, cursor, value_out, value_valid, busy
    );
endinterface

// File: rtl/decimal_entry_encoder.sv
// Six-digit BCD entry from three debounced push-buttons, with a sequential
// BCD-to-binary conversion (one digit per cycle, most significant first).
module decimal_entry_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                    clock_50Mhz,
    input  logic                    reset_n,
    decimal_entry_encoder_if.slave  bus
);
    localparam int unsigned NUM_KEYS   = 3;
    localparam int unsigned KEY_NEXT   = 0;
    localparam int unsigned KEY_INC    = 1;
    localparam int unsigned KEY_COMMIT = 2;
    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned CURSOR_W   = 3;
    localparam int unsigned VALUE_W    = 41;
    localparam int unsigned CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CURSOR_W-1:0] LAST_INDEX = CURSOR_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] sync_meta;
    logic [NUM_KEYS-1:0] sync_key;
    logic [NUM_KEYS-1:0] level;
    logic [NUM_KEYS-1:0] press;
    logic [CNT_W-1:0]    deb_cnt [NUM_KEYS];

    assign key_raw = {bus.key_commit_n, bus.key_inc_n, bus.key_next_n};

    // Two-flop synchronizer, debounce and falling-edge press detect per key
    always_ff @(posedge clock_50Mhz) begin
        if (!reset_n) begin
            sync_meta <= '1;
            sync_key  <= '1;
            level     <= '1;
            press     <= '0;
            for (int k = 0; k < NUM_KEYS; k++) deb_cnt[k] <= '0;
        end else begin
            sync_meta <= key_raw;
            sync_key  <= sync_meta;
            press     <= '0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (sync_key[k] == level[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == CNT_LAST) begin
                    deb_cnt[k] <= '0;
                    level[k]   <= sync_key[k];
                    press[k]   <= level[k];
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    state_t                              state, state_next;
    logic [VALUE_W-1:0]                  acc, acc_next, acc_step_c;
    logic [CURSOR_W-1:0]                 idx, idx_next;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  snap, snap_next;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  digits, digits_next;
    logic [CURSOR_W-1:0]                 cursor, cursor_next;
    logic [VALUE_W-1:0]                  value, value_next;
    logic                                valid, valid_next;
    logic                                busy, busy_next;

    // acc*10 as shift-and-add, plus the current snapshot digit
    assign acc_step_c = VALUE_W'(acc << 3) + VALUE_W'(acc << 1) + VALUE_W'(snap[idx]);

    always_ff @(posedge clock_50Mhz) begin
        if (!reset_n) begin
            state  <= IDLE;
            acc    <= '0;
            idx    <= '0;
            snap   <= '0;
            digits <= '0;
            cursor <= '0;
            value  <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_next;
            acc    <= acc_next;
            idx    <= idx_next;
            snap   <= snap_next;
            digits <= digits_next;
            cursor <= cursor_next;
            value  <= value_next;
            valid  <= valid_next;
            busy   <= busy_next;
        end
    end

    // Commit beats inc/next in IDLE; all key events are ignored outside IDLE
    always_comb begin
        state_next  = state;
        acc_next    = acc;
        idx_next    = idx;
        snap_next   = snap;
        digits_next = digits;
        cursor_next = cursor;
        value_next  = value;
        valid_next  = 1'b0;
        busy_next   = busy;
        case (state)
            IDLE: begin
                if (press[KEY_COMMIT]) begin
                    state_next = CONVERT;
                    acc_next   = '0;
                    idx_next   = LAST_INDEX;
                    snap_next  = digits;
                    busy_next  = 1'b1;
                end else begin
                    if (press[KEY_INC]) begin
                        digits_next[cursor] = (digits[cursor] == DIGIT_W'(9)) ?
                                              '0 : digits[cursor] + DIGIT_W'(1);
                    end
                    if (press[KEY_NEXT]) begin
                        cursor_next = (cursor == LAST_INDEX) ? '0 : cursor + CURSOR_W'(1);
                    end
                end
            end
            CONVERT: begin
                acc_next = acc_step_c;
                if (idx == '0) begin
                    state_next = DONE;
                    value_next = acc_step_c;
                    valid_next = 1'b1;
                    busy_next  = 1'b0;
                end else begin
                    idx_next = idx - CURSOR_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.digits_bcd  = digits;
    assign bus.cursor      = cursor;
    assign bus.value_out   = value;
    assign bus.value_valid = valid;
    assign bus.busy        = busy;
endmodule

// File: tb/tb_decimal_entry_encoder.sv
// Randomized key-press bench for decimal_entry_encoder against a digit-array
// model; debounce shortened to 4 cycles.
module tb_decimal_entry_encoder;
    localparam int unsigned DEB = 4;

    logic clock_50Mhz = 1'b0;
    logic reset_n     = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   m_digit [6];
    int   m_cursor;

    decimal_entry_encoder_if bus ();

    decimal_entry_encoder #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clock_50Mhz (clock_50Mhz),
        .reset_n     (reset_n),
        .bus         (bus)
    );

    always #10 clock_50Mhz = ~clock_50Mhz;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model_digits();
        logic [23:0] p = '0;
        for (int k = 0; k < 6; k++) p[4*k +: 4] = 4'(m_digit[k]);
        return p;
    endfunction

    function automatic longint model_value();
        longint v = 0;
        longint w = 1;
        for (int k = 0; k < 6; k++) begin
            v += longint'(m_digit[k]) * w;
            w *= 10;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 6; k++) m_digit[k] = 0;
        m_cursor = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock_50Mhz);
    endtask

    task automatic keys(input bit nxt, input bit inc, input bit com);
        bus.key_next_n   = ~nxt;
        bus.key_inc_n    = ~inc;
        bus.key_commit_n = ~com;
    endtask

    task automatic check_entry(input string tag);
        check({tag, "_digits"}, 64'(bus.digits_bcd), 64'(model_digits()));
        check({tag, "_cursor"}, 64'(bus.cursor), 64'(m_cursor));
    endtask

    // Hold inc/next low for len cycles; a press survives debounce if len >= DEB
    task automatic press(input bit nxt, input bit inc, input int len);
        keys(nxt, inc, 1'b0);
        cycles(len);
        keys(1'b0, 1'b0, 1'b0);
        cycles(12);
        if (len >= int'(DEB)) begin
            if (inc) m_digit[m_cursor] = (m_digit[m_cursor] + 1) % 10;
            if (nxt) m_cursor = (m_cursor + 1) % 6;
        end
    endtask

    task automatic enter(input int value);
        int want [6];
        int v = value;
        for (int k = 0; k < 6; k++) begin
            want[k] = v % 10;
            v = v / 10;
        end
        for (int p = 5; p >= 0; p--) begin
            while (m_cursor != p) press(1'b1, 1'b0, 5);
            while (m_digit[p] != want[p]) press(1'b0, 1'b1, 5);
        end
    endtask

    // Commit with optional inc/next at the same time (with_keys) or during CONVERT (late_keys)
    task automatic commit_run(input string tag, input bit with_keys, input bit late_keys);
        int          busy_first = -1;
        int          busy_cnt   = 0;
        int          vcnt       = 0;
        int          vcycle     = -1;
        logic [40:0] vval       = '0;
        longint      exp_v      = model_value();
        keys(with_keys, with_keys, 1'b1);
        for (int t = 0; t < 40; t++) begin
            @(negedge clock_50Mhz);
            if (bus.busy) begin
                if (busy_first < 0) busy_first = t;
                busy_cnt++;
            end
            if (bus.value_valid) begin
                vcnt++;
                vcycle = t;
                vval   = bus.value_out;
            end
            if (t == 1 && late_keys) keys(1'b1, 1'b1, 1'b1);
            if (t == 7) keys(1'b0, 1'b0, 1'b0);
        end
        check({tag, "_busy_len"}, 64'(busy_cnt), 64'd6);
        check({tag, "_valid_cnt"}, 64'(vcnt), 64'd1);
        check({tag, "_latency"}, 64'(vcycle - busy_first + 1), 64'd7);
        check({tag, "_valid_val"}, 64'(vval), 64'(exp_v));
        check({tag, "_value_hold"}, 64'(bus.value_out), 64'(exp_v));
        check_entry(tag);
    endtask

    task automatic abort_run();
        int seen = -1;
        int vcnt = 0;
        keys(1'b0, 1'b0, 1'b1);
        for (int t = 0; t < 20 && seen < 0; t++) begin
            @(negedge clock_50Mhz);
            if (bus.busy) seen = t;
        end
        check("abort_busy_seen", 64'(seen >= 0), 64'd1);
        cycles(2);
        reset_n = 1'b0;
        keys(1'b0, 1'b0, 1'b0);
        cycles(3);
        reset_n = 1'b1;
        model_reset();
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_value", 64'(bus.value_out), 64'd0);
        for (int t = 0; t < 20; t++) begin
            @(negedge clock_50Mhz);
            if (bus.value_valid) vcnt++;
        end
        check("abort_no_valid", 64'(vcnt), 64'd0);
        check_entry("abort");
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        keys(1'b1, 1'b1, 1'b1);
        reset_n = 1'b0;
        cycles(6);
        check("rst_digits", 64'(bus.digits_bcd), 64'd0);
        check("rst_cursor", 64'(bus.cursor), 64'd0);
        check("rst_value", 64'(bus.value_out), 64'd0);
        check("rst_valid", 64'(bus.value_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        keys(1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        cycles(10);
        check_entry("post_rst");

        press(1'b0, 1'b1, 3);
        check("bounce3", 64'(bus.digits_bcd), 64'd0);
        press(1'b0, 1'b1, 6);
        check("bounce6", 64'(bus.digits_bcd), 64'd1);
        press(1'b0, 1'b1, 100);
        check("hold100", 64'(bus.digits_bcd), 64'd2);

        enter(0);
        for (int k = 0; k < 10; k++) press(1'b0, 1'b1, 5);
        check("wrap_digit", 64'(bus.digits_bcd), 64'd0);
        for (int k = 0; k < 6; k++) press(1'b1, 1'b0, 5);
        check("wrap_cursor", 64'(bus.cursor), 64'd0);

        press(1'b1, 1'b1, 5);
        check_entry("inc_next_same");

        enter(123456);
        check_entry("enter_123456");
        commit_run("commit_123456", 1'b0, 1'b0);
        check("value_123456", 64'(bus.value_out), 64'h1E240);

        enter(999999);
        commit_run("commit_999999", 1'b0, 1'b0);
        check("value_999999", 64'(bus.value_out), 64'hF423F);

        enter(704211);
        commit_run("busy_drop", 1'b0, 1'b1);
        commit_run("commit_prio", 1'b1, 1'b0);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: press(1'b0, 1'b1, int'($urandom_range(4, 12)));
                1: press(1'b1, 1'b0, int'($urandom_range(4, 12)));
                2: press(1'b1, 1'b1, int'($urandom_range(4, 12)));
                3: press(1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(1, 3)));
                default: commit_run("rand_commit", 1'($urandom_range(0, 1)), 1'b0);
            endcase
            check_entry("rand");
        end

        enter(98765);
        commit_run("pre_abort", 1'b0, 1'b0);
        abort_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decimal_entry_encoder.md
DECIMAL_ENTRY_ENCODER -- requirements
Module: decimal_entry_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-level cycles needed to accept a key change (20 ms at 50 MHz).
REQ-002 SHALL use reset reset_n, synchronous, active-low, and clock clock_50Mhz.
REQ-003 SHALL have port clock_50Mhz  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port key_next_n  input  1  raw asynchronous active-low push-button; advances the cursor.
REQ-006 SHALL have port key_inc_n  input  1  raw asynchronous active-low push-button; increments the digit under the cursor.
REQ-007 SHALL have port key_commit_n  input  1  raw asynchronous active-low push-button; starts BCD-to-binary conversion.
REQ-008 SHALL have port digits_bcd  output  [5:0][3:0]  entered digits; index 0 = ones, index 5 = hundred-thousands.
REQ-009 SHALL have port cursor  output  3  selected digit index, 0..5.
REQ-010 SHALL have port value_out  output  41  binary value of the last committed entry; width matches the seven-segment display input.
REQ-011 SHALL have port value_valid  output  1  one-cycle pulse when value_out updates.
REQ-012 SHALL have port busy  output  1  high while a conversion is in progress.

Function
REQ-013 Each key SHALL pass through a two-flop synchronizer before any other use.
REQ-014 Each synchronized key SHALL have its own debounce counter; the debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the debounced level clears the counter.
REQ-015 A press event SHALL be a one-cycle pulse on the 1->0 transition of a debounced level; holding a key SHALL yield exactly one event; release SHALL yield none.
REQ-016 An inc event in IDLE SHALL set digits_bcd[cursor] = digits_bcd[cursor]+1; 9 wraps to 0.
REQ-017 A next event in IDLE SHALL set cursor = cursor+1; 5 wraps to 0.
REQ-018 When inc and next events occur in the same cycle, the increment SHALL apply to the old cursor and the cursor SHALL then advance.
REQ-019 The FSM SHALL have states IDLE, CONVERT and DONE; the reset state is IDLE.
REQ-020 IDLE -> CONVERT on a commit event: accumulator = 0, digit index = 5, digits_bcd snapshotted, busy = 1 from the next cycle.
REQ-021 CONVERT SHALL process one digit per cycle, from index 5 down to index 0: acc = acc*10 + digit, with *10 implemented as (acc<<3)+(acc<<1) in 41 bits; after index 0 it SHALL go to DONE.
REQ-022 DONE SHALL load value_out = acc, pulse value_valid for exactly one cycle, clear busy and return to IDLE.
REQ-023 Latency SHALL be fixed: value_valid high exactly 7 cycles after the commit event pulse cycle.
REQ-024 While busy or in DONE, inc, next and commit events SHALL be dropped, not queued; digits_bcd and cursor SHALL stay unchanged.
REQ-025 A commit event coinciding with an inc or next event in IDLE SHALL take priority; the inc/next event SHALL be dropped.
REQ-026 value_out SHALL hold its value between conversions; the maximum result is 999999 (0xF423F), so no overflow is possible.

Reset
REQ-027 On reset_n = 0 at a clock edge: digits_bcd = 0, cursor = 0, value_out = 0, value_valid = 0, busy = 0, FSM = IDLE, debounce counters = 0, debounced levels = 1 (released).
REQ-028 Reset during CONVERT or DONE SHALL abort the conversion; no value_valid pulse SHALL follow.
REQ-029 Reset SHALL take priority over every event in the same cycle.

Verification (DEBOUNCE_CYCLES = 4)
REQ-030 Reset: assert reset_n = 0 with keys pressed -> all outputs 0, and no events for 4+ cycles after release of reset while keys are held high.
REQ-031 Bounce: key_inc_n low for 3 cycles, then high -> no change; low for 6 cycles -> digit 0 = 1; low for 100 cycles -> still exactly one increment.
REQ-032 Wrap: 10 inc events at cursor 0 -> digit 0 = 0; 6 next events -> cursor = 0.
REQ-033 Entry and commit: enter 1,2,3,4,5,6 into digits 5..0, then commit -> busy for 6 cycles, value_out = 123456 (0x1E240), value_valid high for one cycle exactly 7 cycles after the commit event; repeat with 999999 -> 0xF423F.
REQ-034 Busy drop: inc, next and a second commit during CONVERT -> digits, cursor and value unchanged; exactly one valid pulse.
REQ-035 Abort: reset_n = 0 on the third CONVERT cycle -> busy = 0, value_out = 0, no value_valid pulse for 20 cycles.
